// File: rtl/memory_requester_pkg.sv
// Shared defaults and FSM encoding for the memory requester and its watchdog.
package memory_requester_pkg;

    localparam int ADDRESS_WIDTH_DEF  = 10;
    localparam int DATA_WIDTH_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int ERROR_COUNT_WIDTH  = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_HIGH = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    // The controller must see unlock drop for one cycle (GAP) to restart its sequence.
    function automatic logic drives_unlock(input state_e st);
        return (st == ST_ARM) || (st == ST_WAIT_HIGH) || (st == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/memory_watchdog.sv
// Handshake phase timer: down-counter reloaded on every FSM state entry,
// flags expiry once the current phase has lasted TIMEOUT_CYCLES cycles.
module memory_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = LOAD;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= LOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/memory_requester.sv
// Burst write/read-back requester driving memory_control through an unlock/ready handshake.
//   state     | meaning
//   IDLE      | waiting for start; burst parameters latched on accept
//   ARM       | unlock high, waiting to observe ready low
//   WAIT_HIGH | unlock high, waiting for ready to rise
//   CAPTURE   | read-back sampled and compared against the written word
//   GAP       | unlock low for one cycle, advance to next word
//   DONE      | burst finished; done pulses on the following cycle
module memory_requester
    import memory_requester_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDRESS_WIDTH-1:0]     base_address,
    input  logic [ADDRESS_WIDTH-1:0]     word_count,
    input  logic [DATA_WIDTH-1:0]        seed,
    input  logic                         ready,
    input  logic [DATA_WIDTH-1:0]        buffer,
    output logic                         unlock,
    output logic [ADDRESS_WIDTH-1:0]     address,
    output logic [DATA_WIDTH-1:0]        data,
    output logic                         busy,
    output logic                         done,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count,
    output logic                         timeout,
    output logic [DATA_WIDTH-1:0]        last_readback
);

    state_e                         state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]       address_q, address_d;
    logic [ADDRESS_WIDTH-1:0]       count_q, count_d;
    logic [ADDRESS_WIDTH-1:0]       index_q, index_d;
    logic [DATA_WIDTH-1:0]          data_q, data_d;
    logic [DATA_WIDTH-1:0]          readback_q, readback_d;
    logic [ERROR_COUNT_WIDTH-1:0]   errors_q, errors_d;
    logic                           timeout_q, timeout_d;
    logic                           done_q, done_d;
    logic                           phase_restart;
    logic                           phase_expired;

    memory_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clock),
        .rst_i     (reset),
        .restart_i (phase_restart),
        .expired_o (phase_expired)
    );

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        count_d    = count_q;
        index_d    = index_q;
        data_d     = data_q;
        readback_d = readback_q;
        errors_d   = errors_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // done_q marks the cycle a burst just ended; a start there is dropped
                if (start && !done_q) begin
                    address_d = base_address;
                    data_d    = seed;
                    count_d   = word_count;
                    index_d   = '0;
                    errors_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = (word_count == '0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM: begin
                if (!ready) begin
                    state_d = ST_WAIT_HIGH;
                end else if (phase_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WAIT_HIGH: begin
                if (ready) begin
                    state_d = ST_CAPTURE;
                end else if (phase_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                readback_d = buffer;
                if ((buffer != data_q) && (errors_q != '1)) begin
                    errors_d = errors_q + 1'b1;
                end
                state_d = ST_GAP;
            end
            ST_GAP: begin
                index_d   = index_q + 1'b1;
                address_d = address_q + 1'b1;
                data_d    = data_q + 1'b1;
                state_d   = (index_d == count_q) ? ST_DONE : ST_ARM;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign phase_restart = (state_d != state_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            address_q  <= '0;
            count_q    <= '0;
            index_q    <= '0;
            data_q     <= '0;
            readback_q <= '0;
            errors_q   <= '0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            count_q    <= count_d;
            index_q    <= index_d;
            data_q     <= data_d;
            readback_q <= readback_d;
            errors_q   <= errors_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
        end
    end

    assign unlock        = drives_unlock(state_q);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign address       = address_q;
    assign data          = data_q;
    assign error_count   = errors_q;
    assign timeout       = timeout_q;
    assign last_readback = readback_q;

endmodule

// File: doc/memory_requester.md
MEMORY_REQUESTER -- requirements
Module: memory_requester

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH, default 10, memory address width; DATA_WIDTH, default 16, word width; TIMEOUT_CYCLES, default 16, maximum wait per handshake phase.
REQ-002 Port list SHALL be:
- clock  in  1  rising-edge clock.
- reset  in  1  async reset, active-high.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- base_address  in  10  first word address.
- word_count  in  10  number of words; 0 means an empty burst.
- seed  in  16  data for the first word.
- ready  in  1  completion flag from memory_control.
- buffer  in  16  read-back word from memory_control.
- unlock  out  1  transaction enable to memory_control.
- address  out  10  current word address.
- data  out  16  current write word.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at burst end.
- error_count  out  10  saturating count of read-back mismatches.
- timeout  out  1  sticky; burst aborted on a handshake timeout.
- last_readback  out  16  most recently captured buffer value.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, ARM, WAIT_HIGH, CAPTURE, GAP, DONE.
REQ-005 IDLE: start=1 SHALL latch base_address, word_count and seed, clear error_count, timeout and the index.
- word_count=0 -> DONE.
- otherwise -> ARM.
REQ-006 ARM: unlock=1 and address/data valid and stable; ready=0 -> WAIT_HIGH; ready still 1 after TIMEOUT_CYCLES -> DONE with timeout=1.
REQ-007 WAIT_HIGH: unlock held 1; ready=1 -> CAPTURE; TIMEOUT_CYCLES without ready -> DONE with timeout=1.
REQ-008 CAPTURE: lasts one cycle.
- last_readback<=buffer.
- buffer!=data increments error_count, saturating at 1023.
- unlock<=0.
- -> GAP.
REQ-009 GAP: lasts exactly one cycle with unlock=0 so the controller restarts its sequence.
- Increment index.
- index==latched count -> DONE; else -> ARM.
REQ-010 address SHALL be (base_address+index) mod 2^10; it wraps from 1023 to 0.
REQ-011 data SHALL be (seed+index) mod 2^16.
REQ-012 address and data SHALL change only in GAP or IDLE, never while unlock=1.
REQ-013 DONE: done=1 for one cycle, unlock=0 -> IDLE.
REQ-014 A start pulse in any state other than IDLE SHALL be ignored.
REQ-015 A start pulse coincident with done SHALL be ignored.
REQ-016 unlock SHALL be 0 in IDLE, GAP, DONE and after any timeout.
REQ-017 error_count, timeout and last_readback SHALL hold their values after done until the next accepted start.
REQ-018 The handshake SHALL be rising-edge-of-ready after an observed low; a ready that is already high at ARM entry SHALL NOT complete a word.

Reset
REQ-019 Reset SHALL asynchronously force:
- state=IDLE;
- unlock, busy, done, timeout = 0;
- address, data, error_count, last_readback, index = 0.
REQ-020 Reset mid-burst SHALL drop unlock in the same instant.
REQ-021 After reset release, no transaction SHALL issue until a new start.

Structure
REQ-022 A shared package SHALL hold ADDRESS_WIDTH, DATA_WIDTH, TIMEOUT_CYCLES defaults and the state encoding.
REQ-023 One sub-module, memory_watchdog, SHALL implement the phase timeout counter:
- cleared on each state entry;
- asserts expired at TIMEOUT_CYCLES.
REQ-024 The requester SHALL be verified against memory_control plus spwf_memory instantiated in the bench.

Verification
REQ-025 Single word: base=0x005, count=1, seed=0x1234 -> one unlock window; address=0x005, data=0x1234; last_readback=0x1234; error_count=0; one done pulse.
REQ-026 Wrap: base=0x3FE, count=4, seed=0xFFFE -> addresses 0x3FE, 0x3FF, 0x000, 0x001; data 0xFFFE, 0xFFFF, 0x0000, 0x0001; unlock low for exactly one cycle between words.
REQ-027 Empty burst: count=0 -> done one cycle after the busy cycle; unlock never asserted.
REQ-028 Timeout: bench ties ready=1 constantly -> after 16 ARM cycles timeout=1, done pulses, unlock=0.
REQ-029 Mismatch: bench model corrupts word 2 of count=3 -> error_count=1; done pulses after the third word.
REQ-030 Reset/start misuse:
- reset asserted in WAIT_HIGH -> unlock=0 and busy=0 immediately;
- start pulsed while busy -> ignored, and the burst completes unchanged.
